// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared constants, state encoding and state
// classification helpers for the instruction-memory boot loader.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CKSUM state.
package imem_boot_loader_pkg;

  localparam int unsigned IM_DEPTH = 1024;
  localparam int unsigned ADDR_W   = 10;
  localparam logic [7:0]  MAGIC    = 8'hA5;

  typedef enum logic [2:0] {
    S_WAIT_MAGIC = 3'd0,
    S_LEN_LO     = 3'd1,
    S_LEN_HI     = 3'd2,
    S_DATA       = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CKSUM      = 3'd4,
`endif
    S_RUN        = 3'd5,
    S_ERR        = 3'd6
  } state_t;

  // States in which the loader is willing to take a byte.
  function automatic logic is_rx_state(input state_t s);
    case (s)
      S_WAIT_MAGIC, S_LEN_LO, S_LEN_HI, S_DATA: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CKSUM:                                  return 1'b1;
`endif
      default:                                  return 1'b0;
    endcase
  endfunction

  // States between the MAGIC byte and the end of the frame.
  function automatic logic is_frame_state(input state_t s);
    case (s)
      S_LEN_LO, S_LEN_HI, S_DATA: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CKSUM:                    return 1'b1;
`endif
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// imem_boot_loader_byte_packer: gathers four bytes into a little-endian word.
// First byte lands in bits [7:0]. word_done/word are combinational so the
// parent can register the write in the cycle after the 4th byte.
module imem_boot_loader_byte_packer (
  input  logic        clk,
  input  logic        resetb,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] shift_q;  // the three earlier bytes; the 4th comes straight from byte_data

  assign word_done = byte_valid && (lane == 2'd3);
  assign word      = {byte_data, shift_q};

  // Lane counter and shift assembler; clear drops any partial word.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      lane    <= 2'd0;
      shift_q <= '0;
    end else if (clear) begin
      lane    <= 2'd0;
    end else if (byte_valid) begin
      // NOTE: non-blocking so lane and shift_q both see pre-edge values.
      lane    <= lane + 2'd1;
      shift_q <= {byte_data, shift_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time loader for the RV32I 1024x32 instruction memory.
// Frame: MAGIC, N[7:0], N[15:8], N*4 data bytes (LE words) [, checksum].
// Holds core_resetb low until the frame is written, then releases the core.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing mod-256 sum byte).
module imem_boot_loader
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              resetb,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              core_resetb,
  output logic              busy,
  output logic              err
);

  localparam int unsigned LEN_W = ADDR_W + 1;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = S_CKSUM;
`else
  localparam state_t POST_DATA = S_RUN;
`endif

  state_t           state, next_state;
  logic             accept, data_accept, last_word;
  logic [7:0]       len_lo;
  logic [15:0]      frame_len;
  logic [LEN_W-1:0] len_words, word_cnt;
  logic             pk_done;
  logic [31:0]      pk_word;
  logic             rx_ready_d, busy_d, err_d, core_resetb_d;

  // A byte offered alongside load_req is never taken.
  assign accept      = rx_valid && rx_ready && !load_req;
  assign data_accept = accept && (state == S_DATA);
  assign frame_len   = {rx_data, len_lo};
  assign last_word   = ((word_cnt + LEN_W'(1)) == len_words);

  imem_boot_loader_byte_packer u_packer (
    .clk        (clk),
    .resetb     (resetb),
    .clear      (load_req),
    .byte_valid (data_accept),
    .byte_data  (rx_data),
    .word_done  (pk_done),
    .word       (pk_word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running mod-256 sum of the current frame's data bytes.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      csum <= '0;
    end else if (load_req || (state == S_WAIT_MAGIC)) begin
      csum <= '0;
    end else if (data_accept) begin
      csum <= csum + rx_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= S_WAIT_MAGIC;
    else         state <= next_state;
  end

  // Next state: load_req overrides everything, otherwise advance per accepted byte.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    if (load_req) begin
      next_state = S_WAIT_MAGIC;
    end else if (accept) begin
      case (state)
        S_WAIT_MAGIC: if (rx_data == MAGIC) next_state = S_LEN_LO;
        S_LEN_LO:     next_state = S_LEN_HI;
        S_LEN_HI: begin
          if (frame_len == 16'd0)                next_state = POST_DATA;
          else if (frame_len > 16'(IM_DEPTH))    next_state = S_ERR;
          else                                   next_state = S_DATA;
        end
        S_DATA:       if (pk_done && last_word) next_state = POST_DATA;
`ifdef LOADER_CHECKSUM_EN
        S_CKSUM:      next_state = (rx_data == csum) ? S_RUN : S_ERR;
`endif
        default:      next_state = state;
      endcase
    end
  end

  // Output decode from the upcoming state; the core is released one cycle
  // after the final data write, but directly after a checksum or N==0 frame.
  always_comb begin
    rx_ready_d    = is_rx_state(next_state);
    busy_d        = is_frame_state(next_state);
    err_d         = (next_state == S_ERR);
    core_resetb_d = (next_state == S_RUN) && (state != S_DATA);
  end

  // Registered outputs and the IM write port.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_ready    <= 1'b1;
      busy        <= 1'b0;
      err         <= 1'b0;
      core_resetb <= 1'b0;
      im_we       <= 1'b0;
      im_wdata    <= '0;
    end else begin
      rx_ready    <= rx_ready_d;
      busy        <= busy_d;
      err         <= err_d;
      core_resetb <= core_resetb_d;
      im_we       <= pk_done;
      if (pk_done) im_wdata <= pk_word;
    end
  end

  // Length capture, word counter and write address.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      im_waddr  <= '0;
      len_lo    <= '0;
      len_words <= '0;
      word_cnt  <= '0;
    end else if (load_req) begin
      im_waddr  <= '0;
      word_cnt  <= '0;
    end else begin
      if (im_we) im_waddr <= im_waddr + ADDR_W'(1);
      if (accept && (state == S_LEN_LO)) len_lo <= rx_data;
      if (accept && (state == S_LEN_HI)) begin
        len_words <= frame_len[LEN_W-1:0];
        word_cnt  <= '0;
      end else if (pk_done) begin
        word_cnt  <= word_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: bench for imem_boot_loader. Define LOADER_CHECKSUM_EN
// for both bench and RTL to cover the checksum frame format.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int         DEPTH = 1024;
  localparam logic [7:0] SOF   = 8'hA5;

  logic        clk_tb = 1'b0;
  logic        resetb;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        load_req;
  logic        im_we;
  logic [9:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        core_resetb;
  logic        busy;
  logic        err;

  imem_boot_loader dut (
    .clk         (clk_tb),
    .resetb      (resetb),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .load_req    (load_req),
    .im_we       (im_we),
    .im_waddr    (im_waddr),
    .im_wdata    (im_wdata),
    .core_resetb (core_resetb),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk_tb = ~clk_tb;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk_tb) cyc <= cyc + 1;

  // Observed IM writes and release timing.
  logic [9:0]  obs_addr_q[$];
  logic [31:0] obs_data_q[$];
  int          last_we_cyc = -1;
  int          rise_cyc    = -1;

  always @(negedge clk_tb) begin
    if (im_we === 1'b1) begin
      obs_addr_q.push_back(im_waddr);
      obs_data_q.push_back(im_wdata);
      last_we_cyc = cyc;
    end
    if (core_resetb === 1'b1 && rise_cyc < 0) rise_cyc = cyc;
  end

  // Stimulus stream and reference expectations.
  logic [7:0]  stim_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  bit          exp_err, exp_run, need_cksum;
  logic [7:0]  model_sum;

  // Frame parser: skip to SOF, read LE length, gather LE words, sum bytes.
  task automatic model_parse();
    int i = 0;
    int n;
    logic [7:0] sum = 8'h00;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_err = 1'b0; exp_run = 1'b0; need_cksum = 1'b0; model_sum = 8'h00;
    while (i < stim_q.size() && stim_q[i] != SOF) i++;
    if (i + 3 > stim_q.size()) return;
    n = int'(stim_q[i+1]) + 256 * int'(stim_q[i+2]);
    i += 3;
    if (n > DEPTH) begin exp_err = 1'b1; return; end
    for (int w = 0; w < n; w++) begin
      if (i + 4 > stim_q.size()) return;
      exp_addr_q.push_back(10'(w));
      exp_data_q.push_back({stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]});
      for (int k = 0; k < 4; k++) sum = sum + stim_q[i+k];
      i += 4;
    end
    model_sum = sum;
`ifdef LOADER_CHECKSUM_EN
    if (i >= stim_q.size()) begin need_cksum = 1'b1; return; end
    if (stim_q[i] == sum) exp_run = 1'b1;
    else                  exp_err = 1'b1;
`else
    exp_run = 1'b1;
`endif
  endtask

  task automatic finish_frame();
    model_parse();
`ifdef LOADER_CHECKSUM_EN
    if (need_cksum) begin
      stim_q.push_back(model_sum);
      model_parse();
    end
`endif
  endtask

  task automatic build_random_frame(input int n_words, input int n_garbage);
    logic [7:0] g;
    stim_q.delete();
    repeat (n_garbage) begin
      g = 8'($urandom_range(0, 255));
      if (g == SOF) g = 8'h00;
      stim_q.push_back(g);
    end
    stim_q.push_back(SOF);
    stim_q.push_back(8'(n_words));
    stim_q.push_back(8'(n_words >> 8));
    repeat (4 * n_words) stim_q.push_back(8'($urandom_range(0, 255)));
    finish_frame();
  endtask

  task automatic clear_log();
    obs_addr_q.delete();
    obs_data_q.delete();
    last_we_cyc = -1;
    rise_cyc    = -1;
  endtask

  // Called and returns at a negedge; outputs then reflect the load_req cycle.
  task automatic pulse_load_req(input bit offer);
    load_req = 1'b1;
    rx_valid = offer;
    rx_data  = SOF;
    @(negedge clk_tb);
    load_req = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int waited = 0;
    ok = 1'b1;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1) begin
      @(negedge clk_tb);
      waited++;
      if (waited > 64) begin ok = 1'b0; rx_valid = 1'b0; return; end
    end
    @(negedge clk_tb);
  endtask

  task automatic send_stim(input int max_gap);
    bit ok;
    foreach (stim_q[k]) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk_tb);
      send_byte(stim_q[k], ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL byte_accept_timeout: byte %0d (0x%02h) not accepted, rx_ready=%b want 1",
                 k, stim_q[k], rx_ready);
        return;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk_tb);
  endtask

  task automatic test_reset();
    resetb = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; load_req = 1'b0;
    repeat (2) @(negedge clk_tb);
    checks++; if (rx_ready !== 1'b1)     begin failures++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    checks++; if (im_we !== 1'b0)        begin failures++; $display("FAIL reset_im_we: got %b want 0", im_we); end
    checks++; if (im_waddr !== 10'd0)    begin failures++; $display("FAIL reset_im_waddr: got %h want 0", im_waddr); end
    checks++; if (im_wdata !== 32'd0)    begin failures++; $display("FAIL reset_im_wdata: got %h want 0", im_wdata); end
    checks++; if (core_resetb !== 1'b0)  begin failures++; $display("FAIL reset_core_resetb: got %b want 0", core_resetb); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0)          begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    resetb = 1'b1;
    repeat (2) @(negedge clk_tb);
    checks++; if (rx_ready !== 1'b1 || core_resetb !== 1'b0)
      begin failures++; $display("FAIL idle_after_reset: rx_ready=%b core_resetb=%b want 1/0", rx_ready, core_resetb); end
  endtask

  task automatic test_two_words();
    pulse_load_req(1'b0);
    clear_log();
    stim_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    finish_frame();
    send_stim(0);
    settle();
    checks++; if (obs_data_q.size() != exp_data_q.size())
      begin failures++; $display("FAIL two_words_count: got %0d writes want %0d", obs_data_q.size(), exp_data_q.size()); end
    for (int i = 0; i < exp_data_q.size() && i < obs_data_q.size(); i++) begin
      checks++;
      if ({obs_addr_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
        failures++;
        $display("FAIL two_words_write%0d: got [%h]=%h want [%h]=%h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
    checks++; if (core_resetb !== exp_run || err !== exp_err)
      begin failures++; $display("FAIL two_words_status: core_resetb=%b err=%b want %b/%b", core_resetb, err, exp_run, exp_err); end
    checks++; if (rx_ready !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL two_words_run_idle: rx_ready=%b busy=%b want 0/0", rx_ready, busy); end
`ifndef LOADER_CHECKSUM_EN
    checks++; if (rise_cyc - last_we_cyc != 1)
      begin failures++; $display("FAIL two_words_release: core_resetb rose %0d cycles after last im_we, want 1", rise_cyc - last_we_cyc); end
`endif
  endtask

  task automatic test_skip_garbage();
    pulse_load_req(1'b0);
    clear_log();
    stim_q = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    finish_frame();
    send_stim(1);
    settle();
    checks++; if (obs_data_q.size() != exp_data_q.size())
      begin failures++; $display("FAIL garbage_count: got %0d writes want %0d", obs_data_q.size(), exp_data_q.size()); end
    for (int i = 0; i < exp_data_q.size() && i < obs_data_q.size(); i++) begin
      checks++;
      if ({obs_addr_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
        failures++;
        $display("FAIL garbage_write%0d: got [%h]=%h want [%h]=%h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
    checks++; if (core_resetb !== exp_run)
      begin failures++; $display("FAIL garbage_release: core_resetb=%b want %b", core_resetb, exp_run); end
  endtask

  task automatic test_too_long();
    pulse_load_req(1'b0);
    clear_log();
    stim_q = {8'hA5, 8'h01, 8'h04};
    finish_frame();
    send_stim(0);
    settle();
    checks++; if (obs_data_q.size() != exp_data_q.size())
      begin failures++; $display("FAIL too_long_writes: got %0d writes want %0d", obs_data_q.size(), exp_data_q.size()); end
    checks++; if (err !== exp_err)
      begin failures++; $display("FAIL too_long_err: got %b want %b", err, exp_err); end
    checks++; if (core_resetb !== 1'b0 || rx_ready !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL too_long_outputs: core_resetb=%b rx_ready=%b busy=%b want 0/0/0", core_resetb, rx_ready, busy); end
    pulse_load_req(1'b0);
    checks++; if (err !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL too_long_recover: err=%b rx_ready=%b busy=%b want 0/1/0", err, rx_ready, busy); end
  endtask

  task automatic test_abort_partial();
    pulse_load_req(1'b0);
    clear_log();
    stim_q = {8'hA5, 8'h02, 8'h00};
    repeat (6) stim_q.push_back(8'($urandom_range(0, 255)));
    model_parse();
    send_stim(1);
    settle();
    checks++; if (obs_data_q.size() != exp_data_q.size())
      begin failures++; $display("FAIL abort_pre_writes: got %0d writes want %0d", obs_data_q.size(), exp_data_q.size()); end
    // Offer a MAGIC byte alongside load_req; it must not be taken.
    pulse_load_req(1'b1);
    checks++; if (im_waddr !== 10'd0 || busy !== 1'b0 || core_resetb !== 1'b0)
      begin failures++; $display("FAIL abort_restart: im_waddr=%h busy=%b core_resetb=%b want 0/0/0", im_waddr, busy, core_resetb); end
    clear_log();
    build_random_frame(1, 0);
    send_stim(0);
    settle();
    checks++; if (obs_data_q.size() != exp_data_q.size())
      begin failures++; $display("FAIL abort_new_count: got %0d writes want %0d", obs_data_q.size(), exp_data_q.size()); end
    for (int i = 0; i < exp_data_q.size() && i < obs_data_q.size(); i++) begin
      checks++;
      if ({obs_addr_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
        failures++;
        $display("FAIL abort_new_write%0d: got [%h]=%h want [%h]=%h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 6; f++) begin
      n = (f == 0) ? 0 : int'($urandom_range(1, 6));
      pulse_load_req(1'b0);
      clear_log();
      build_random_frame(n, int'($urandom_range(0, 3)));
      send_stim(2);
      settle();
      checks++; if (obs_data_q.size() != exp_data_q.size())
        begin failures++; $display("FAIL rand%0d_count: got %0d writes want %0d", f, obs_data_q.size(), exp_data_q.size()); end
      for (int i = 0; i < exp_data_q.size() && i < obs_data_q.size(); i++) begin
        checks++;
        if ({obs_addr_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
          failures++;
          $display("FAIL rand%0d_write%0d: got [%h]=%h want [%h]=%h", f, i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
        end
      end
      checks++; if (core_resetb !== exp_run || err !== exp_err)
        begin failures++; $display("FAIL rand%0d_status: core_resetb=%b err=%b want %b/%b", f, core_resetb, err, exp_run, exp_err); end
`ifndef LOADER_CHECKSUM_EN
      if (n > 0) begin
        checks++; if (rise_cyc - last_we_cyc != 1)
          begin failures++; $display("FAIL rand%0d_release: gap %0d cycles want 1", f, rise_cyc - last_we_cyc); end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int start_cyc, stop_cyc;
    pulse_load_req(1'b0);
    clear_log();
    build_random_frame(DEPTH, 0);
    start_cyc = cyc;
    send_stim(0);
    stop_cyc = cyc;
    settle();
    checks++; if (stop_cyc - start_cyc != stim_q.size())
      begin failures++; $display("FAIL b2b_stalls: took %0d cycles for %0d bytes", stop_cyc - start_cyc, stim_q.size()); end
    checks++; if (obs_data_q.size() != exp_data_q.size())
      begin failures++; $display("FAIL b2b_count: got %0d writes want %0d", obs_data_q.size(), exp_data_q.size()); end
    for (int i = 0; i < exp_data_q.size() && i < obs_data_q.size(); i++) begin
      checks++;
      if ({obs_addr_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
        failures++;
        $display("FAIL b2b_write%0d: got [%h]=%h want [%h]=%h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
    checks++; if (core_resetb !== exp_run || err !== exp_err)
      begin failures++; $display("FAIL b2b_status: core_resetb=%b err=%b want %b/%b", core_resetb, err, exp_run, exp_err); end
  endtask

  task automatic test_resetb_mid_frame();
    pulse_load_req(1'b0);
    clear_log();
    stim_q = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stim(0);
    resetb = 1'b0;
    #1;
    checks++; if (rx_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || core_resetb !== 1'b0)
      begin failures++; $display("FAIL async_reset_ctrl: rx_ready=%b busy=%b err=%b core_resetb=%b want 1/0/0/0", rx_ready, busy, err, core_resetb); end
    checks++; if (im_we !== 1'b0 || im_waddr !== 10'd0 || im_wdata !== 32'd0)
      begin failures++; $display("FAIL async_reset_port: im_we=%b im_waddr=%h im_wdata=%h want 0/0/0", im_we, im_waddr, im_wdata); end
    @(negedge clk_tb);
    resetb = 1'b1;
    @(negedge clk_tb);
    clear_log();
    build_random_frame(1, 0);
    send_stim(0);
    settle();
    checks++; if (obs_data_q.size() != exp_data_q.size())
      begin failures++; $display("FAIL post_reset_count: got %0d writes want %0d", obs_data_q.size(), exp_data_q.size()); end
    for (int i = 0; i < exp_data_q.size() && i < obs_data_q.size(); i++) begin
      checks++;
      if ({obs_addr_q[i], obs_data_q[i]} !== {exp_addr_q[i], exp_data_q[i]}) begin
        failures++;
        $display("FAIL post_reset_write%0d: got [%h]=%h want [%h]=%h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] ck [2];
    ck[0] = 8'h82;
    ck[1] = 8'h83;
    for (int t = 0; t < 2; t++) begin
      pulse_load_req(1'b0);
      clear_log();
      stim_q = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      stim_q.push_back(ck[t]);
      model_parse();
      send_stim(0);
      settle();
      checks++; if (core_resetb !== exp_run || err !== exp_err)
        begin failures++; $display("FAIL cksum%0d_status: core_resetb=%b err=%b want %b/%b", t, core_resetb, err, exp_run, exp_err); end
      checks++; if (obs_data_q.size() != exp_data_q.size())
        begin failures++; $display("FAIL cksum%0d_count: got %0d writes want %0d", t, obs_data_q.size(), exp_data_q.size()); end
    end
  endtask
`endif

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_words();
    test_skip_garbage();
    test_too_long();
    test_abort_partial();
    test_random_frames();
    test_back_to_back();
    test_resetb_mid_frame();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
